// File: rtl/seq_frame_pkg.sv
// Shared definitions for the 1101-preamble serial framer and its detector bench.
package seq_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_PAR,
    ST_GAP
  } state_e;

  localparam logic [3:0] PREAMBLE = 4'b1101;
  localparam int         PRE_LEN  = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter that saturates at zero and flags it.
module seq_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_frame_tx.sv
// Serial framer: 1101 preamble, payload MSB-first, optional parity, zero gap.
// Define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(max3(DATA_W, GAP, PRE_LEN) + 1);
  localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
  localparam state_e POST_DATA = (GAP > 0) ? ST_GAP : ST_IDLE;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_bit_q, tx_bit_d;
  logic              tx_active_q, tx_active_d;
  logic              frame_done_q, frame_done_d;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_zero;
  logic [1:0]        pre_idx;
  logic              accept;

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  seq_bit_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .cnt_o      (cnt_q),
    .zero_o     (cnt_zero)
  );

`ifdef SEQ_FRAME_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^in_data;
    end
  end
`endif

  // tx_bit is registered, so each branch computes the bit that is on the line after this edge.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    tx_bit_d     = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    pre_idx      = 2'(cnt_q - CNT_W'(1));
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_PRE;
          shreg_d      = in_data;
          cnt_load     = 1'b1;
          cnt_load_val = PRE_LOAD;
          tx_bit_d     = PREAMBLE[PRE_LEN-1];
        end
      end
      ST_PRE: begin
        if (cnt_zero) begin
          state_d      = ST_DATA;
          cnt_load     = 1'b1;
          cnt_load_val = DATA_LOAD;
          tx_bit_d     = shreg_q[DATA_W-1];
        end else begin
          tx_bit_d = PREAMBLE[pre_idx];
        end
      end
      ST_DATA: begin
        if (!cnt_zero) begin
          shreg_d  = shreg_q << 1;
          tx_bit_d = shreg_d[DATA_W-1];
        end else begin
`ifdef SEQ_FRAME_TX_PARITY_EN
          state_d      = ST_PAR;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
          tx_bit_d     = parity_q;
`else
          state_d      = POST_DATA;
          cnt_load     = 1'b1;
          cnt_load_val = GAP_LOAD;
`endif
        end
      end
`ifdef SEQ_FRAME_TX_PARITY_EN
      ST_PAR: begin
        state_d      = POST_DATA;
        cnt_load     = 1'b1;
        cnt_load_val = GAP_LOAD;
      end
`endif
      ST_GAP: begin
        if (cnt_zero) begin
          state_d  = ST_IDLE;
          cnt_load = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    tx_active_d  = (state_d != ST_IDLE);
    frame_done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      tx_bit_q     <= 1'b0;
      tx_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      tx_bit_q     <= tx_bit_d;
      tx_active_q  <= tx_active_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_bit     = tx_bit_q;
  assign tx_active  = tx_active_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx with a per-cycle expected-bit scoreboard and a 1101 detector.
module tb_seq_frame_tx;
  import seq_frame_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx_bit;
  logic       tx_active;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic act;
    logic b;
    logic done;
    logic z;
  } exp_t;

  exp_t exp_q[$];
  bit   det_chk = 1'b0;
  int   done_seen = 0;
  int   z_seen = 0;

  seq_frame_tx #(.DATA_W(8), .GAP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_bit     (tx_bit),
    .tx_active  (tx_active),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Mealy 1101 detector fed by the serial line, overlap allowed.
  typedef enum logic [1:0] {D0, D1, D11, D110} det_e;
  det_e det_s;
  logic det_z;
  assign det_z = (det_s == D110) && tx_bit;

  always @(posedge clk) begin
    if (rst) det_s <= D0;
    else begin
      case (det_s)
        D0:      det_s <= tx_bit ? D1 : D0;
        D1:      det_s <= tx_bit ? D11 : D0;
        D11:     det_s <= tx_bit ? D11 : D110;
        default: det_s <= tx_bit ? D1 : D0;
      endcase
    end
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    for (int i = 3; i >= 0; i--) exp_q.push_back('{1'b1, PREAMBLE[i], 1'b0, (i == 0)});
    for (int i = 7; i >= 0; i--) exp_q.push_back('{1'b1, d[i], 1'b0, 1'b0});
`ifdef SEQ_FRAME_TX_PARITY_EN
    exp_q.push_back('{1'b1, ^d, 1'b0, 1'b0});
`endif
    for (int i = 0; i < 2; i++) exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  // One clock: predict acceptance from pre-edge inputs, then compare the post-edge outputs.
  task automatic step();
    bit         acc;
    logic [7:0] d;
    exp_t       e;
    acc = in_valid && !rst && (exp_q.size() == 0);
    d   = in_data;
    @(posedge clk);
    #1;
    if (rst) exp_q.delete();
    if (acc) push_frame(d);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{1'b0, 1'b0, 1'b0, 1'b0};
    if (frame_done) done_seen++;
    if (det_z) z_seen++;
    check("tx_bit", tx_bit, e.b);
    check("tx_active", tx_active, e.act);
    check("frame_done", frame_done, e.done);
    check("in_ready", in_ready, (exp_q.size() == 0) && !rst);
    if (det_chk) check("det_z", det_z, e.z);
    $display("t=%0t rst=%0b vld=%0b rdy=%0b bit=%0b act=%0b done=%0b z=%0b",
             $time, rst, in_valid, in_ready, tx_bit, tx_active, frame_done, det_z);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Single frame A5
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (16) step();

    // Back-to-back 00 then FF, detector loopback
    done_seen = 0; z_seen = 0; det_chk = 1'b1;
    in_data = 8'h00; in_valid = 1'b1;
    step();
    in_data = 8'hFF;
    repeat (15) step();
    in_valid = 1'b0;
    repeat (16) step();
    det_chk = 1'b0;
    check_n("b2b_frame_done_pulses", done_seen, 2);
    check_n("b2b_detector_hits", z_seen, 2);

    // Reset during the third payload bit
    done_seen = 0;
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2) step();
    check_n("abort_no_frame_done", done_seen, 0);
    in_data = 8'h3C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (16) step();

    // Payload stability with in_data churning and in_valid held while busy
    in_data = 8'h5A; in_valid = 1'b1;
    step();
    for (int i = 0; i < 40 && exp_q.size() > 1; i++) begin
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Parity-sensitive payload
    in_data = 8'h07; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (17) step();
    check_n("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter that drives the 1-bit input of the team's Mealy "1101" sequence detector.
- Accepts a parallel payload word over a valid/ready handshake. Emits the 4-bit preamble 1101, then the payload MSB-first, then an optional parity bit, then idle-zero gap bits.
- A downstream 1101 detector fires once per frame, on the last preamble bit. The block sits between the test/control logic and the serial line.

Parameters:
- DATA_W, 8, payload width in bits (≥1).
- GAP, 2, number of forced-zero bits after each frame (≥0).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  DATA_W  payload word; sampled only on acceptance.
- in_valid  input  1  payload word available.
- in_ready  output  1  block can accept a word this cycle.
- tx_bit  output  1  serial line; registered; idles at 0.
- tx_active  output  1  high while a preamble/data/parity/gap bit is on tx_bit.
- frame_done  output  1  one-cycle pulse when a frame, including its gap, completes.

Behaviour:
- Reset (synchronous, active-high) and its values:
  - On the clk edge where rst=1: state←IDLE, tx_bit←0, tx_active←0, frame_done←0, shift register←0, counter←0.
  - rst has priority over every other event.
  - in_ready = (state==IDLE) & ~rst, so no word is accepted while rst is high.
- Handshake:
  - Acceptance happens on a posedge with in_valid & in_ready.
  - in_data is latched into the shift register at that edge; later changes to in_data are ignored.
  - in_valid high while in_ready=0 has no effect; no queueing.
- FSM states: IDLE, PRE, DATA, PAR, GAP.
  - IDLE: tx_bit=0, tx_active=0. On acceptance → PRE, counter=3.
  - PRE: tx_bit = PREAMBLE[counter], giving 1,1,0,1 over 4 cycles. After 4 bits → DATA, counter=DATA_W-1.
  - DATA: tx_bit = shreg[DATA_W-1]; shift left one bit per cycle. After DATA_W bits → PAR if PARITY_EN, else GAP (or IDLE when GAP=0).
  - PAR: 1 cycle; see Optional Feature.
  - GAP: tx_bit=0 and tx_active=1 for GAP cycles → IDLE.
- Latency:
  - Acceptance at edge k → first preamble bit on tx_bit from edge k until edge k+1.
  - Each serial bit lasts exactly one clk cycle.
- frame_done: high for exactly the one cycle following the edge that enters IDLE from the final frame state.
- Frame length: 4 + DATA_W (+1 with parity) + GAP cycles with tx_active=1.
- Back-to-back: IDLE lasts at least 1 cycle between frames, because acceptance occurs in IDLE. Total frame period is frame length + 1 when in_valid is held high.
- tx_active never glitches low inside a frame. tx_bit is 0 in every cycle where tx_active=0.
- Reset mid-frame: the frame is aborted, the partial word is discarded, no frame_done is produced, tx_bit=0 from the next cycle, and in_ready=1 once rst deasserts.
- Counter width: $clog2(max(DATA_W,GAP,4)+1). Counter decrements and never wraps; each state's exit is decoded at counter==0.

Optional Feature:
- Macro: SEQ_FRAME_TX_PARITY_EN.
- Defined: after DATA, one PAR cycle with tx_bit = even parity (XOR) of the latched payload, taken from a copy made at acceptance. Frame length grows by 1.
- Undefined: no PAR state or parity logic; DATA goes directly to GAP/IDLE.

Decomposition:
- Package seq_frame_pkg:
  - state enum (IDLE, PRE, DATA, PAR, GAP);
  - localparam PREAMBLE = 4'b1101;
  - localparam PRE_LEN = 4.
- This same package is shared with the detector bench.
- One natural sub-module: seq_bit_counter, a loadable down-counter with a zero flag, instantiated once and reloaded on every state change.

Test Plan:
- All cases use DATA_W=8, GAP=2, no parity unless stated.
- Single frame: in_data=8'hA5, in_valid pulse → tx_bit = 1101 10100101 00, tx_active high for 14 cycles, frame_done pulses once, in_ready low for 14 cycles.
- Back-to-back: in_valid held, data 8'h00 then 8'hFF → 1101 00000000 00 0 1101 11111111 00. Exactly one idle cycle between frames; 2 frame_done pulses.
- Detector loopback: tx_bit drives the detector's in, payload 8'h00 → detector z asserts exactly once, in the cycle of the 4th preamble bit.
- Reset mid-frame: assert rst during data bit 3 of 8'hA5 for 1 cycle → tx_bit=0 next cycle, no frame_done, in_ready=1 after release, then a new 8'h3C frame transmits correctly.
- Input stability: change in_data every cycle during a frame of 8'h5A → serial payload is still 01011010; in_valid while busy is ignored.
- SEQ_FRAME_TX_PARITY_EN defined: 8'hA5 → parity bit 0 (frame 15 bits); 8'h07 → parity bit 1.
